// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - RV32I load/store unit over a word-only dmem using read-modify-write
module lsu_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [31:0]         wdata_q;
  logic [31:0]         word_q;
  logic                err_q;
  logic [ADDR_W-1:0]   mem_a_q;

  logic                accept;
  logic                req_err;
  logic [ADDR_W-1:0]   word_addr;
  logic                mem_active;
  logic [31:0]         merged;
  logic [31:0]         shifted;
  logic [31:0]         load_ext;

  assign accept     = req_valid && (state_q == IDLE);
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_active = (state_q == READ) || (state_q == WRITE);

  // Classify the incoming request: illegal funct3 or misaligned address.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:         req_err = 1'b0;
      3'b001:         req_err = req_addr[0];
      3'b010:         req_err = |req_addr[1:0];
      3'b100:         req_err = req_we;
      3'b101:         req_err = req_we | req_addr[0];
      default:        req_err = 1'b1;
    endcase
  end

  // Next-state logic; errors bypass memory, word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                            state_d = RESP;
          else if (req_we && req_funct3 == 3'b010) state_d = WRITE;
          else                                     state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight request without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the request on acceptance and the memory word during READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      word_q   <= 32'h0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        we_q     <= req_we;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state_q == READ) word_q <= mem_RD;
    end
  end

  // Remember the last memory address so mem_A holds outside READ/WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             mem_a_q <= '0;
    else if (mem_active) mem_a_q <= word_addr;
  end

  // Merge store data into the word read back; word stores take wdata whole.
  always_comb begin
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Select the addressed lane of the loaded word and extend it.
  always_comb begin
    shifted = word_q >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = word_q;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_ext : 32'h0;
  assign mem_WE    = (state_q == WRITE);
  assign mem_WD    = (state_q == WRITE) ? merged : 32'h0;
  assign mem_A     = mem_active ? word_addr : mem_a_q;

endmodule
